// File: rtl/snake_input_ctrl.sv
// Snake game input stage: button sync/debounce, legal-turn FIFO and game tick sequencer.
// Defining SNAKE_TURBO_EN adds btn_turbo, which halves the tick period while held.
module snake_input_ctrl #(
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned DEB_CYCLES = 250_000,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned INIT_DIR   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_up,
    input  logic                      btn_right,
    input  logic                      btn_down,
    input  logic                      btn_left,
`ifdef SNAKE_TURBO_EN
    input  logic                      btn_turbo,
`endif
    input  logic                      run,
    input  logic                      game_over,
    output logic                      gameTick,
    output logic                      move_enable,
    output logic [1:0]                move,
    output logic [1:0]                cur_dir,
    output logic [$clog2(QDEPTH):0]   queue_count
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
`ifdef SNAKE_TURBO_EN
    localparam int unsigned NB = 5;
`else
    localparam int unsigned NB = 4;
`endif
    localparam logic [CW-1:0] TermFull = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DebLast  = DW'(DEB_CYCLES - 1);
    localparam logic [1:0]    InitDir  = 2'(INIT_DIR);
    localparam logic [AW:0]   QFull    = (AW + 1)'(QDEPTH);

    typedef enum logic [1:0] {StIdle, StApply, StTick} state_e;

    logic [NB-1:0] btn_raw, sync1_q, sync2_q, deb_q, deb_d, rise;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [DW-1:0] deb_cnt_d [NB];
    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d, term;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [1:0]    fifo_q [QDEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [AW-1:0] tail_idx;
    logic [1:0]    head, tail, ref_dir, press_dir;
    logic          press_vld, empty, full, push, pop;

`ifdef SNAKE_TURBO_EN
    assign btn_raw = {btn_turbo, btn_left, btn_down, btn_right, btn_up};
    // >= comparison makes an already-passed half period terminal immediately.
    assign term    = deb_q[NB-1] ? CW'(TICK_DIV / 2 - 1) : TermFull;
`else
    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};
    assign term    = TermFull;
`endif

    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press_vld = |rise[3:0];
        press_dir = 2'd0;
        if (rise[0])      press_dir = 2'd0;
        else if (rise[1]) press_dir = 2'd1;
        else if (rise[2]) press_dir = 2'd2;
        else if (rise[3]) press_dir = 2'd3;
    end

    assign count    = wptr_q - rptr_q;
    assign empty    = (count == '0);
    assign full     = (count == QFull);
    assign tail_idx = wptr_q[AW-1:0] - 1'b1;
    assign head     = fifo_q[rptr_q[AW-1:0]];
    assign tail     = fifo_q[tail_idx];
    // The tail is also the reference after a same-cycle pop of the last entry.
    assign ref_dir  = empty ? cur_dir_q : tail;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        cur_dir_d   = cur_dir_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        push        = 1'b0;
        pop         = 1'b0;
        gameTick    = 1'b0;
        move_enable = 1'b0;
        move        = cur_dir_q;
        if (game_over) begin
            state_d = StIdle;
            rptr_d  = wptr_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        if (tick_cnt_q >= term) begin
                            tick_cnt_d = '0;
                            state_d    = StApply;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                StApply: begin
                    if (!empty) begin
                        pop         = 1'b1;
                        move_enable = 1'b1;
                        move        = head;
                        cur_dir_d   = head;
                        rptr_d      = rptr_q + 1'b1;
                    end
                    state_d = StTick;
                end
                StTick: begin
                    gameTick = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (press_vld && (!full || pop) && (press_dir != ref_dir) &&
                (press_dir != (ref_dir ^ 2'b10))) begin
                push   = 1'b1;
                wptr_d = wptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            cur_dir_q  <= InitDir;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            cur_dir_q  <= cur_dir_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q[AW-1:0]] <= press_dir;
    end

    assign cur_dir     = cur_dir_q;
    assign queue_count = count;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios then random buttons, all checked every cycle
// against a queue-based behavioural model.
module tb_snake_input_ctrl;
    localparam int TD = 8;
    localparam int DB = 4;
    localparam int QD = 2;
    localparam int ID = 1;

    logic clk = 1'b0;
    logic reset, btn_up, btn_right, btn_down, btn_left, run, game_over;
    logic gameTick, move_enable;
    logic [1:0] move, cur_dir, queue_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: sync pipeline, last DB synchronized samples, debounced levels, turn queue.
    bit [3:0]    m_s1, m_s2, m_deb;
    bit [DB-1:0] m_hist [4];
    int          m_q[$];
    int          m_cur, m_cnt;
    int          m_since_tc;  // 0: waiting, 1: cycle after terminal count, 2: tick cycle

    snake_input_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB), .QDEPTH(QD), .INIT_DIR(ID)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_right(btn_right),
        .btn_down(btn_down), .btn_left(btn_left), .run(run), .game_over(game_over),
        .gameTick(gameTick), .move_enable(move_enable), .move(move), .cur_dir(cur_dir),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0] raw;
        bit         rise [4];
        bit         has;
        int         dir, rf;
        raw = {btn_left, btn_down, btn_right, btn_up};
        if (reset !== 1'b1) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int b = 0; b < 4; b++) m_hist[b] = '0;
            m_q.delete();
            m_cur = ID; m_cnt = 0; m_since_tc = 0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
            rise[b] = 1'b0;
            // Level accepted once the last DB samples all disagree with it.
            if (m_deb[b] ? (m_hist[b] == '0) : (&m_hist[b])) begin
                m_deb[b] = ~m_deb[b];
                rise[b] = m_deb[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        has = 1'b0;
        dir = 0;
        for (int b = 0; b < 4; b++) if (rise[b] && !has) begin has = 1'b1; dir = b; end
        if (game_over === 1'b1) begin
            m_q.delete();
            m_since_tc = 0;
            return;
        end
        if (m_since_tc == 0) begin
            if (run === 1'b1) begin
                if (m_cnt == TD - 1) begin m_cnt = 0; m_since_tc = 1; end
                else m_cnt++;
            end
        end else if (m_since_tc == 1) begin
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            m_since_tc = 2;
        end else begin
            m_since_tc = 0;
        end
        if (has && m_q.size() < QD) begin
            rf = (m_q.size() > 0) ? m_q[$] : m_cur;
            if (dir != rf && dir != (rf ^ 2)) m_q.push_back(dir);
        end
    endtask

    task automatic cyc();
        bit me;
        @(posedge clk);
        model_step();
        #1;
        me = (m_since_tc == 1) && (m_q.size() > 0) && (game_over !== 1'b1);
        check("gameTick", gameTick, ((m_since_tc == 2) && (game_over !== 1'b1)) ? 1 : 0);
        check("move_enable", move_enable, me ? 1 : 0);
        check("move", move, me ? m_q[0] : m_cur);
        check("cur_dir", cur_dir, m_cur);
        check("queue_count", queue_count, m_q.size());
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return gameTick === 1'b1;
            1:       return move_enable === 1'b1;
            default: return queue_count !== 2'd0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int max, output bit found, output int n);
        n = 0;
        while (!sig(which) && n < max) begin cyc(); n++; end
        found = sig(which);
    endtask

    initial begin
        int ticks, mes, n, seg;
        bit found;
        reset = 1'b0; run = 1'b0; game_over = 1'b0;
        btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
        repeat (3) cyc();
        check("rst_tick", gameTick, 0);
        check("rst_me", move_enable, 0);
        check("rst_move", move, 1);
        check("rst_dir", cur_dir, 1);
        check("rst_qc", queue_count, 0);

        // Counter holds during apply/tick, so one game step spans TICK_DIV + 2 cycles.
        reset = 1'b1; run = 1'b1;
        ticks = 0; mes = 0;
        repeat (30) begin cyc(); ticks += int'(gameTick); mes += int'(move_enable); end
        check("idle_ticks", ticks, 3);
        check("idle_me", mes, 0);
        check("idle_dir", cur_dir, 1);

        btn_left = 1'b1; repeat (10) cyc();
        check("reverse_drop", queue_count, 0);
        btn_left = 1'b0; repeat (8) cyc();
        btn_right = 1'b1; repeat (10) cyc();
        check("same_drop", queue_count, 0);
        btn_right = 1'b0; repeat (8) cyc();
        check("drop_dir", cur_dir, 1);

        btn_down = 1'b1; cyc();
        btn_down = 1'b0; cyc();
        btn_down = 1'b1;
        wait_sig(2, 20, found, n);
        check("bounce_push", found, 1);
        check("bounce_lat", n, 6);
        wait_sig(1, 15, found, n);
        check("down_me", found, 1);
        check("down_move", move, 2);
        cyc();
        check("down_tick", gameTick, 1);
        check("down_dir", cur_dir, 2);
        btn_down = 1'b0; repeat (8) cyc();

        btn_right = 1'b1;
        wait_sig(1, 30, found, n);
        check("right_me", found, 1);
        check("right_move", move, 1);
        btn_right = 1'b0; repeat (8) cyc();

        wait_sig(0, 15, found, n);
        check("seq_sync", found, 1);
        btn_up = 1'b1; cyc();
        btn_left = 1'b1; cyc();
        btn_down = 1'b1; repeat (7) cyc();
        check("seq_full", queue_count, 2);
        check("seq_me0", move_enable, 1);
        check("seq_mv0", move, 0);
        btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b0;
        cyc();
        wait_sig(1, 15, found, n);
        check("seq_me1", found, 1);
        check("seq_mv1", move, 3);
        repeat (8) cyc();

        btn_up = 1'b1; btn_left = 1'b1; repeat (6) cyc();
        check("prio_qc", queue_count, 1);
        wait_sig(1, 15, found, n);
        check("prio_me", found, 1);
        check("prio_move", move, 0);
        btn_up = 1'b0; btn_left = 1'b0; repeat (8) cyc();

        wait_sig(0, 15, found, n);
        check("go_sync", found, 1);
        btn_right = 1'b1; cyc();
        btn_down = 1'b1; repeat (7) cyc();
        check("go_pre_qc", queue_count, 2);
        game_over = 1'b1; cyc();
        check("go_flush", queue_count, 0);
        btn_right = 1'b0; btn_down = 1'b0;
        ticks = 0;
        repeat (25) begin cyc(); ticks += int'(gameTick); end
        check("go_no_tick", ticks, 0);
        game_over = 1'b0;
        wait_sig(0, 15, found, n);
        check("go_resume", found, 1);

        seg = 0;
        for (int i = 0; i < 600; i++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 12);
                btn_up    = ($urandom_range(0, 2) == 0);
                btn_right = ($urandom_range(0, 2) == 0);
                btn_down  = ($urandom_range(0, 2) == 0);
                btn_left  = ($urandom_range(0, 2) == 0);
                run       = ($urandom_range(0, 7) != 0);
                game_over = ($urandom_range(0, 15) == 0);
            end
            reset = !(i >= 300 && i < 302);
            cyc();
            seg--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
